// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller driving one full-adder cell built from two half adders.
// Optional subtract mode (sub port, inverted B, carry preset) is enabled by defining SERIAL_ADDER_SUB_EN.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               inv_b_q, inv_b_d;

    logic               accept;
    logic               preset;
    logic               fa_b, ha0_s, ha0_c, ha1_c, fa_sum, fa_cout;
    logic [WIDTH-1:0]   res_full;

`ifdef SERIAL_ADDER_SUB_EN
    assign preset = sub;
`else
    assign preset = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert B into the cell, carry preset to 1.
    assign fa_b = b_q[0] ^ inv_b_q;

    half_adder u_ha0 (.x(a_q[0]), .y(fa_b),    .s(ha0_s),  .c(ha0_c));
    half_adder u_ha1 (.x(ha0_s),  .y(carry_q), .s(fa_sum), .c(ha1_c));
    assign fa_cout = ha0_c | ha1_c;

    // The final bit lands straight in sum, so only WIDTH-1 result bits are held.
    assign res_full = {fa_sum, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        inv_b_d = inv_b_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_full[WIDTH-1:1];
                carry_d = fa_cout;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_full;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                accept  = start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            res_d   = '0;
            cnt_d   = '0;
            carry_d = preset;
            inv_b_d = preset;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            inv_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            inv_b_q <= inv_b_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
